// File: rtl/opto_bus_sequencer_if.sv
// Avalon-MM slave port bundle for the opto field-bus sequencer.
interface opto_bus_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/opto_bus_sequencer.sv
// Hardware sequencer for timed read/write cycles on the 16-bit opto-isolated field bus.
// Data direction, rw_n and strobe_n are driven from registered state; completion comes
// from the remote ack line through a two-flop synchroniser.
module opto_bus_sequencer #(
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned STROBE_CYC  = 8,
    parameter int unsigned TURN_CYC    = 2,
    parameter int unsigned TIMEOUT_CYC = 200
) (
    input  logic                       clk,
    input  logic                       reset_n,
    opto_bus_sequencer_if.slave        avs,
    inout  wire  [15:0]                bidir_port,
    output logic                       rw_n,
    output logic                       strobe_n,
    input  logic                       ack
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SETUP    = 3'd1;
    localparam logic [2:0] STROBE   = 3'd2;
    localparam logic [2:0] WAIT_ACK = 3'd3;
    localparam logic [2:0] HOLD     = 3'd4;
    localparam logic [2:0] TURN     = 3'd5;

    localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LAST  = 8'(STROBE_CYC - 1);
    localparam logic [7:0] TURN_LAST    = 8'(TURN_CYC - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        oe_q, oe_d;
    logic        rw_n_q, rw_n_d;
    logic        strobe_n_q, strobe_n_d;
    logic        is_write_q, is_write_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic [15:0] wr_data_q;
    logic [15:0] readdata_q;
    logic        ack_meta_q, ack_s_q;
    logic        done_q, timeout_q, busy_err_q, irq_en_q;
    logic        set_done, set_timeout;

    logic wr_en, start_wr, start_rd, start_req, start_ok, clr, busy;

    assign wr_en     = avs.chipselect && !avs.write_n;
    assign start_wr  = wr_en && (avs.address == 2'd0);
    assign start_rd  = wr_en && (avs.address == 2'd1) && avs.writedata[0];
    assign clr       = wr_en && (avs.address == 2'd1) && avs.writedata[1];
    assign start_req = start_wr || start_rd;
    assign busy      = (state_q != IDLE);
    assign start_ok  = start_req && !busy;

    assign bidir_port = oe_q ? wr_data_q : 16'hzzzz;
    assign rw_n       = rw_n_q;
    assign strobe_n   = strobe_n_q;
    assign avs.readdata = readdata_q;
    assign avs.irq      = (done_q || timeout_q) && irq_en_q;

    // Two-flop synchroniser for the asynchronous remote ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Cycle sequencer next-state; the last STROBE clock doubles as the first ack check.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        oe_d        = oe_q;
        rw_n_d      = rw_n_q;
        strobe_n_d  = strobe_n_q;
        is_write_d  = is_write_q;
        rd_data_d   = rd_data_q;
        set_done    = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d    = SETUP;
                    cnt_d      = 8'd0;
                    rw_n_d     = start_rd;
                    oe_d       = start_wr;
                    is_write_d = start_wr;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    strobe_n_d = 1'b0;
                    state_d    = STROBE;
                    cnt_d      = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STROBE: begin
                if (cnt_q != STROBE_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (ack_s_q) begin
                    if (!is_write_q) rd_data_d = bidir_port;
                    strobe_n_d = 1'b1;
                    state_d    = HOLD;
                    cnt_d      = 8'd0;
                end else begin
                    state_d = WAIT_ACK;
                    cnt_d   = 8'd0;
                end
            end
            WAIT_ACK: begin
                if (ack_s_q) begin
                    if (!is_write_q) rd_data_d = bidir_port;
                    strobe_n_d = 1'b1;
                    state_d    = HOLD;
                    cnt_d      = 8'd0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    set_timeout = 1'b1;
                    strobe_n_d  = 1'b1;
                    state_d     = HOLD;
                    cnt_d       = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == SETUP_LAST) begin
                    oe_d    = 1'b0;
                    rw_n_d  = 1'b1;
                    state_d = TURN;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            TURN: begin
                // Counter saturates so a stuck ack can hold us here indefinitely.
                if (cnt_q != TURN_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (!ack_s_q) begin
                    state_d  = IDLE;
                    set_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state and registered bus controls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            oe_q       <= 1'b0;
            rw_n_q     <= 1'b1;
            strobe_n_q <= 1'b1;
            is_write_q <= 1'b0;
            rd_data_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            oe_q       <= oe_d;
            rw_n_q     <= rw_n_d;
            strobe_n_q <= strobe_n_d;
            is_write_q <= is_write_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Register file and sticky status; set events take priority over clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_data_q  <= 16'd0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            busy_err_q <= 1'b0;
        end else begin
            if (start_wr && !busy) wr_data_q <= avs.writedata;
            if (wr_en && (avs.address == 2'd1)) irq_en_q <= avs.writedata[2];
            // A timed-out cycle reports timeout only, not done.
            if (set_done && !timeout_q) done_q <= 1'b1;
            else if (start_ok || clr)   done_q <= 1'b0;
            if (set_timeout)            timeout_q <= 1'b1;
            else if (start_ok || clr)   timeout_q <= 1'b0;
            if (start_req && busy)      busy_err_q <= 1'b1;
            else if (clr)               busy_err_q <= 1'b0;
        end
    end

    // Read data is registered from the address presented in the previous cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= 16'd0;
        end else if (avs.chipselect && avs.write_n) begin
            case (avs.address)
                2'd0:    readdata_q <= rd_data_q;
                2'd1:    readdata_q <= {13'b0, irq_en_q, 2'b0};
                2'd2:    readdata_q <= {11'b0, ack_s_q, busy_err_q, timeout_q, done_q, busy};
                default: readdata_q <= 16'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_opto_bus_sequencer.sv
// Self-checking bench for opto_bus_sequencer: register reads and strobe widths are
// scoreboarded, bus drive and direction are checked around each cycle.
module tb_opto_bus_sequencer;

    localparam int unsigned SETUP_CYC   = 4;
    localparam int unsigned STROBE_CYC  = 8;
    localparam int unsigned TURN_CYC    = 2;
    localparam int unsigned TIMEOUT_CYC = 200;

    logic        clk;
    logic        reset_n;
    logic        ack;
    logic        rw_n;
    logic        strobe_n;
    logic        remote_oe;
    logic [15:0] remote_data;
    wire  [15:0] bidir_port;

    opto_bus_sequencer_if avs ();

    assign bidir_port = remote_oe ? remote_data : 16'hzzzz;

    opto_bus_sequencer #(
        .SETUP_CYC   (SETUP_CYC),
        .STROBE_CYC  (STROBE_CYC),
        .TURN_CYC    (TURN_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .avs        (avs),
        .bidir_port (bidir_port),
        .rw_n       (rw_n),
        .strobe_n   (strobe_n),
        .ack        (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] rd_q[$];
    logic [31:0] strobe_q[$];
    int unsigned low_cnt  = 0;
    logic        chk_read_bus = 1'b0;
    int unsigned bad_rd   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected strobe-low width when ack rises k clocks after strobe_n falls.
    function automatic int unsigned exp_strobe(input int unsigned k);
        return (k + 3 > STROBE_CYC) ? k + 3 : STROBE_CYC;
    endfunction

    task automatic avs_write(input logic [1:0] addr, input logic [15:0] data);
        @(negedge clk);
        avs.chipselect = 1'b1;
        avs.write_n    = 1'b0;
        avs.address    = addr;
        avs.writedata  = data;
        @(negedge clk);
        avs.chipselect = 1'b0;
        avs.write_n    = 1'b1;
    endtask

    task automatic avs_read(input logic [1:0] addr, input logic [15:0] exp, input string tag);
        rd_q.push_back({16'd0, exp});
        @(negedge clk);
        avs.chipselect = 1'b1;
        avs.write_n    = 1'b1;
        avs.address    = addr;
        @(negedge clk);
        avs.chipselect = 1'b0;
        check(tag, {16'd0, avs.readdata}, rd_q.pop_front());
    endtask

    task automatic wait_strobe(input logic level, input int max, input string tag);
        for (int i = 0; i < max; i++) begin
            if (strobe_n === level) break;
            @(negedge clk);
        end
        check(tag, {31'd0, strobe_n}, {31'd0, level});
    endtask

    // Strobe-width monitor: pops the expected width when strobe_n returns high.
    always @(negedge clk) begin
        if (!reset_n) begin
            low_cnt = 0;
        end else if (strobe_n === 1'b0) begin
            low_cnt++;
        end else if (low_cnt != 0) begin
            if (strobe_q.size() == 0) check("strobe_unexpected", low_cnt, 0);
            else check("strobe_len", low_cnt, strobe_q.pop_front());
            low_cnt = 0;
        end
        if (chk_read_bus && (rw_n !== 1'b1 || bidir_port !== 16'h1234)) bad_rd++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        reset_n        = 1'b0;
        ack            = 1'b0;
        remote_oe      = 1'b0;
        remote_data    = 16'h0000;
        avs.chipselect = 1'b0;
        avs.write_n    = 1'b1;
        avs.address    = 2'd0;
        avs.writedata  = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_strobe_n", {31'd0, strobe_n}, 32'd1);
        check("rst_rw_n", {31'd0, rw_n}, 32'd1);
        check("rst_irq", {31'd0, avs.irq}, 32'd0);
        check("rst_readdata", {16'd0, avs.readdata}, 32'd0);
        reset_n = 1'b1;
        avs_read(2'd2, 16'h0000, "rst_status");

        // Write cycle: setup, strobe width, hold, then stuck ack holds TURN.
        strobe_q.push_back(exp_strobe(3));
        avs_write(2'd0, 16'hA55A);
        n = 0;
        for (int i = 0; i < 20 && strobe_n !== 1'b0; i++) begin
            if (bidir_port === 16'hA55A && rw_n === 1'b0) n++;
            @(negedge clk);
        end
        check("wr_setup_cycles", n, SETUP_CYC);
        wait_strobe(1'b0, 1, "wr_fall");
        repeat (3) @(negedge clk);
        ack = 1'b1;
        wait_strobe(1'b1, 40, "wr_rise");
        n = 0;
        for (int i = 0; i < 20 && bidir_port === 16'hA55A; i++) begin
            n++;
            @(negedge clk);
        end
        check("wr_hold_cycles", n, SETUP_CYC);
        check("wr_rw_n_released", {31'd0, rw_n}, 32'd1);
        repeat (10) @(negedge clk);
        avs_read(2'd2, 16'h0011, "stuck_ack_status");
        ack = 1'b0;
        repeat (4) @(negedge clk);
        avs_read(2'd2, 16'h0002, "wr_done_status");

        // Read cycle with late ack; DUT must never drive or flip direction.
        remote_data  = 16'h1234;
        remote_oe    = 1'b1;
        bad_rd       = 0;
        chk_read_bus = 1'b1;
        strobe_q.push_back(exp_strobe(10));
        avs_write(2'd1, 16'h0001);
        wait_strobe(1'b0, 20, "rd_fall");
        repeat (10) @(negedge clk);
        ack = 1'b1;
        wait_strobe(1'b1, 40, "rd_rise");
        repeat (3) @(negedge clk);
        chk_read_bus = 1'b0;
        check("rd_bus_bad_samples", bad_rd, 0);
        ack = 1'b0;
        repeat (6) @(negedge clk);
        remote_oe = 1'b0;
        avs_read(2'd0, 16'h1234, "rd_data");
        avs_read(2'd2, 16'h0002, "rd_done_status");

        // Read with no ack: timeout, irq, then clear.
        avs_write(2'd1, 16'h0004);
        avs_read(2'd1, 16'h0004, "irq_en_readback");
        strobe_q.push_back(STROBE_CYC + TIMEOUT_CYC);
        avs_write(2'd1, 16'h0005);
        wait_strobe(1'b0, 20, "to_fall");
        wait_strobe(1'b1, 300, "to_rise");
        avs_read(2'd2, 16'h0005, "to_status_busy");
        repeat (10) @(negedge clk);
        avs_read(2'd2, 16'h0004, "to_status_idle");
        check("to_irq", {31'd0, avs.irq}, 32'd1);
        avs_read(2'd0, 16'h1234, "to_data_kept");
        avs_write(2'd1, 16'h0006);
        check("to_irq_cleared", {31'd0, avs.irq}, 32'd0);
        avs_read(2'd2, 16'h0000, "to_status_cleared");

        // Start while busy: ignored, flagged, cycle completes.
        strobe_q.push_back(exp_strobe(2));
        avs_write(2'd0, 16'h0F0F);
        wait_strobe(1'b0, 20, "be_fall");
        avs_write(2'd0, 16'hFFFF);
        check("be_bus_unchanged", {16'd0, bidir_port}, 32'h0000_0F0F);
        ack = 1'b1;
        wait_strobe(1'b1, 40, "be_rise");
        repeat (5) @(negedge clk);
        ack = 1'b0;
        repeat (6) @(negedge clk);
        avs_read(2'd2, 16'h000A, "be_status");
        avs_write(2'd1, 16'h0002);
        avs_read(2'd2, 16'h0000, "be_cleared");
        avs_read(2'd3, 16'h0000, "addr3_zero");

        // Reset during STROBE takes effect without a clock edge.
        avs_read(2'd0, 16'h1234, "pre_reset_data");
        avs_write(2'd0, 16'h5555);
        wait_strobe(1'b0, 20, "rst_mid_fall");
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_strobe_n", {31'd0, strobe_n}, 32'd1);
        check("rst_mid_rw_n", {31'd0, rw_n}, 32'd1);
        check("rst_mid_bus_released", {31'd0, bidir_port === 16'h5555}, 32'd0);
        check("rst_mid_readdata", {16'd0, avs.readdata}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        avs_read(2'd2, 16'h0000, "post_rst_status");
        avs_read(2'd0, 16'h0000, "post_rst_data");
        strobe_q.push_back(exp_strobe(3));
        avs_write(2'd0, 16'h3C3C);
        n = 0;
        for (int i = 0; i < 20 && strobe_n !== 1'b0; i++) begin
            if (bidir_port === 16'h3C3C && rw_n === 1'b0) n++;
            @(negedge clk);
        end
        check("post_rst_setup", n, SETUP_CYC);
        repeat (3) @(negedge clk);
        ack = 1'b1;
        wait_strobe(1'b1, 40, "post_rst_rise");
        ack = 1'b0;
        repeat (12) @(negedge clk);
        avs_read(2'd2, 16'h0002, "post_rst_done");

        check("scoreboard_empty", strobe_q.size() + rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
